mmio_uart_fifo: RTL and testbench

Buffered UART peripheral on the CPU memory-mapped I/O bus. Replaces the single-byte, poll-per-character UART window with parametrised TX and RX FIFOs, sticky error flags, a status/count register, flush controls and a level interrupt. Sits beside the existing MMIO decoder, selected by its own `oe` strobe, and wraps the existing `UARTTX`/`UARTRX` serial cores.

---
 rtl/mmio_uart_fifo_pkg.sv | 58 +++++
 rtl/mmio_uart_fifo_if.sv | 20 ++
 rtl/mmio_uart_fifo_serial.sv | 112 +++++++++++
 rtl/mmio_uart_fifo_sync_fifo.sv | 58 +++++
 rtl/mmio_uart_fifo.sv | 166 ++++++++++++++++
 tb/tb_mmio_uart_fifo.sv | 228 ++++++++++++++++++++++
 6 files changed

// File: rtl/mmio_uart_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_fifo_pkg
// Purpose  : Register map, bit positions and TX FSM states for the MMIO UART.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_uart_fifo_pkg;

    // Word offsets decoded from addr[3:2]; mirrored by the software headers.
    localparam logic [1:0] MMIO_UART_REG_DATA   = 2'd0;
    localparam logic [1:0] MMIO_UART_REG_STATUS = 2'd1;
    localparam logic [1:0] MMIO_UART_REG_CTRL   = 2'd2;

    localparam int MMIO_UART_ST_TX_FULL      = 0;
    localparam int MMIO_UART_ST_TX_EMPTY     = 1;
    localparam int MMIO_UART_ST_RX_FULL      = 2;
    localparam int MMIO_UART_ST_RX_EMPTY     = 3;
    localparam int MMIO_UART_ST_TX_DROP      = 4;
    localparam int MMIO_UART_ST_RX_OVERRUN   = 5;
    localparam int MMIO_UART_ST_TX_COUNT_LSB = 8;
    localparam int MMIO_UART_ST_RX_COUNT_LSB = 16;

    localparam int MMIO_UART_CTRL_RX_IRQ_EN  = 0;
    localparam int MMIO_UART_CTRL_TX_IRQ_EN  = 1;
    localparam int MMIO_UART_CTRL_RX_FLUSH   = 2;
    localparam int MMIO_UART_CTRL_TX_FLUSH   = 3;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_KICK = 2'd1,
        T_HOLD = 2'd2
    } tx_state_t;

    function automatic logic [31:0] mmio_uart_status(
        input logic       tx_full,
        input logic       tx_empty,
        input logic       rx_full,
        input logic       rx_empty,
        input logic       tx_drop,
        input logic       rx_overrun,
        input logic [7:0] tx_count,
        input logic [7:0] rx_count
    );
        logic [31:0] s;
        s = '0;
        s[MMIO_UART_ST_TX_FULL]    = tx_full;
        s[MMIO_UART_ST_TX_EMPTY]   = tx_empty;
        s[MMIO_UART_ST_RX_FULL]    = rx_full;
        s[MMIO_UART_ST_RX_EMPTY]   = rx_empty;
        s[MMIO_UART_ST_TX_DROP]    = tx_drop;
        s[MMIO_UART_ST_RX_OVERRUN] = rx_overrun;
        s[MMIO_UART_ST_TX_COUNT_LSB +: 8] = tx_count;
        s[MMIO_UART_ST_RX_COUNT_LSB +: 8] = rx_count;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_uart_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_fifo_if
// Purpose  : CPU MMIO bus bundle (select, address, write data/enables, read).
// Revision : 1.0 - initial release
// ============================================================================
interface mmio_uart_fifo_if #(
    parameter int ADDR_W = 16
);
    logic              oe;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        we;
    logic [31:0]       rdata;
    logic              valid;

    modport master (output oe, addr, wdata, we, input  rdata, valid);
    modport slave  (input  oe, addr, wdata, we, output rdata, valid);
endinterface
`default_nettype wire

// File: rtl/mmio_uart_fifo_serial.sv
`default_nettype none
// ============================================================================
// Module   : UARTTX / UARTRX
// Purpose  : 8N1 serial transmit and receive cores, SERIAL_WCNT clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module UARTTX #(
    parameter int SERIAL_WCNT = 100
) (
    input  logic       CLK,
    input  logic       RST_X,
    input  logic [7:0] DATA,
    input  logic       WE,
    output logic       TXD,
    output logic       READY
);
    logic [9:0]  r_shift;
    logic [15:0] r_wcnt;
    logic [3:0]  r_bits;
    logic        r_busy;

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            r_shift <= '1;
            r_wcnt  <= '0;
            r_bits  <= '0;
            r_busy  <= 1'b0;
        end else if (!r_busy) begin
            if (WE) begin
                r_shift <= {1'b1, DATA, 1'b0};
                r_wcnt  <= '0;
                r_bits  <= 4'd10;
                r_busy  <= 1'b1;
            end
        end else if (r_wcnt == 16'(SERIAL_WCNT - 1)) begin
            // Shift in ones so the line rests high once the frame is out.
            r_wcnt  <= '0;
            r_shift <= {1'b1, r_shift[9:1]};
            r_bits  <= r_bits - 4'd1;
            if (r_bits == 4'd1) r_busy <= 1'b0;
        end else begin
            r_wcnt <= r_wcnt + 16'd1;
        end
    end

    assign TXD   = r_shift[0];
    assign READY = !r_busy;
endmodule

module UARTRX #(
    parameter int SERIAL_WCNT = 100
) (
    input  logic       CLK,
    input  logic       RST_X,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       VALID
);
    logic        r_s1;
    logic        r_s2;
    logic        r_busy;
    logic [15:0] r_wcnt;
    logic [3:0]  r_bit;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_busy  <= 1'b0;
            r_wcnt  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_s1    <= RXD;
            r_s2    <= r_s1;
            r_valid <= 1'b0;
            if (!r_busy) begin
                // Half a bit to reach the middle of the start bit.
                if (!r_s2) begin
                    r_busy <= 1'b1;
                    r_wcnt <= 16'(SERIAL_WCNT / 2);
                    r_bit  <= '0;
                end
            end else if (r_wcnt != '0) begin
                r_wcnt <= r_wcnt - 16'd1;
            end else begin
                r_wcnt <= 16'(SERIAL_WCNT - 1);
                r_bit  <= r_bit + 4'd1;
                if (r_bit == 4'd0) begin
                    if (r_s2) r_busy <= 1'b0;
                end else if (r_bit == 4'd9) begin
                    r_busy <= 1'b0;
                    if (r_s2) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                    end
                end else begin
                    r_shift <= {r_s2, r_shift[7:1]};
                end
            end
        end
    end

    assign DATA  = r_data;
    assign VALID = r_valid;
endmodule
`default_nettype wire

// File: rtl/mmio_uart_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with push/pop/flush, full/empty and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop frees the slot the same-cycle push needs, so full does not block it.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/mmio_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_fifo
// Purpose  : Buffered MMIO UART: TX/RX FIFOs, sticky errors, CTRL/STATUS, irq.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_uart_fifo
    import mmio_uart_fifo_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int CPU_FREQ = 100000000,
    parameter int BAUDRATE = 1000000,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mmio_uart_fifo_if.slave       bus,
    output logic                  txd,
    input  logic                  rxd,
    output logic                  irq
);
    localparam int SERIAL_WCNT = CPU_FREQ / BAUDRATE;
    localparam int TX_CW       = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW       = $clog2(RX_DEPTH) + 1;

    logic             w_rd, w_wr;
    logic [1:0]       w_sel;
    logic             w_rst_x;
    logic             w_unused;

    logic             w_tx_push, w_tx_pop, w_tx_flush, w_tx_full, w_tx_empty, w_tx_drop;
    logic [7:0]       w_tx_dout;
    logic [TX_CW-1:0] w_tx_count;
    logic             w_rx_valid, w_rx_pop, w_rx_flush, w_rx_full, w_rx_empty, w_rx_overrun;
    logic [7:0]       w_rx_din, w_rx_dout;
    logic [RX_CW-1:0] w_rx_count;
    logic             w_tx_ready;
    logic [31:0]      w_rd_val;

    tx_state_t        r_tx_state;
    logic             r_tx_we;
    logic [7:0]       r_tx_data;
    logic [31:0]      r_rdata;
    logic             r_valid, r_irq;
    logic             r_tx_drop, r_rx_overrun;
    logic             r_rx_irq_en, r_tx_irq_en;

    assign w_rd    = bus.oe && (bus.we == 4'b0000);
    assign w_wr    = bus.oe && bus.we[0];
    assign w_sel   = bus.addr[3:2];
    assign w_rst_x = !rst;
    assign w_unused = ^{bus.addr[ADDR_W-1:4], bus.addr[1:0], bus.wdata[31:8]};

    assign w_tx_push  = w_wr && (w_sel == MMIO_UART_REG_DATA);
    assign w_rx_pop   = w_rd && (w_sel == MMIO_UART_REG_DATA);
    assign w_tx_flush = w_wr && (w_sel == MMIO_UART_REG_CTRL) && bus.wdata[MMIO_UART_CTRL_TX_FLUSH];
    assign w_rx_flush = w_wr && (w_sel == MMIO_UART_REG_CTRL) && bus.wdata[MMIO_UART_CTRL_RX_FLUSH];
    assign w_tx_pop   = (r_tx_state == T_IDLE) && !w_tx_empty && w_tx_ready;

    // A same-cycle pop makes room, and a flush discards the byte silently.
    assign w_tx_drop    = w_tx_push  && w_tx_full && !w_tx_pop && !w_tx_flush;
    assign w_rx_overrun = w_rx_valid && w_rx_full && !w_rx_pop && !w_rx_flush;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(w_tx_push), .pop(w_tx_pop), .flush(w_tx_flush),
        .din(bus.wdata[7:0]), .dout(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty),
        .count(w_tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(w_rx_valid), .pop(w_rx_pop), .flush(w_rx_flush),
        .din(w_rx_din), .dout(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty),
        .count(w_rx_count)
    );

    UARTTX #(.SERIAL_WCNT(SERIAL_WCNT)) u_tx (
        .CLK(clk), .RST_X(w_rst_x), .DATA(r_tx_data), .WE(r_tx_we),
        .TXD(txd), .READY(w_tx_ready)
    );

    UARTRX #(.SERIAL_WCNT(SERIAL_WCNT)) u_rx (
        .CLK(clk), .RST_X(w_rst_x), .RXD(rxd), .DATA(w_rx_din), .VALID(w_rx_valid)
    );

    always_comb begin
        w_rd_val = '0;
        case (w_sel)
            MMIO_UART_REG_DATA:
                w_rd_val = {w_rx_empty, 23'h0, (w_rx_empty ? 8'h00 : w_rx_dout)};
            MMIO_UART_REG_STATUS:
                w_rd_val = mmio_uart_status(w_tx_full, w_tx_empty, w_rx_full, w_rx_empty,
                                            r_tx_drop, r_rx_overrun,
                                            8'(w_tx_count), 8'(w_rx_count));
            MMIO_UART_REG_CTRL:
                w_rd_val = {30'h0, r_tx_irq_en, r_rx_irq_en};
            default:
                w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata      <= '0;
            r_valid      <= 1'b0;
            r_irq        <= 1'b0;
            r_tx_drop    <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_rx_irq_en  <= 1'b0;
            r_tx_irq_en  <= 1'b0;
        end else begin
            r_valid <= w_rd;
            if (w_rd) r_rdata <= w_rd_val;

            // New errors win over a same-cycle write-1-to-clear.
            if (w_tx_drop)
                r_tx_drop <= 1'b1;
            else if (w_wr && (w_sel == MMIO_UART_REG_STATUS) && bus.wdata[MMIO_UART_ST_TX_DROP])
                r_tx_drop <= 1'b0;
            if (w_rx_overrun)
                r_rx_overrun <= 1'b1;
            else if (w_wr && (w_sel == MMIO_UART_REG_STATUS) && bus.wdata[MMIO_UART_ST_RX_OVERRUN])
                r_rx_overrun <= 1'b0;

            if (w_wr && (w_sel == MMIO_UART_REG_CTRL)) begin
                r_rx_irq_en <= bus.wdata[MMIO_UART_CTRL_RX_IRQ_EN];
                r_tx_irq_en <= bus.wdata[MMIO_UART_CTRL_TX_IRQ_EN];
            end

            r_irq <= (r_rx_irq_en && !w_rx_empty) || (r_tx_irq_en && w_tx_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= T_IDLE;
            r_tx_we    <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            case (r_tx_state)
                T_IDLE: begin
                    if (w_tx_pop) begin
                        r_tx_data  <= w_tx_dout;
                        r_tx_we    <= 1'b1;
                        r_tx_state <= T_KICK;
                    end
                end
                T_KICK: begin
                    r_tx_we    <= 1'b0;
                    r_tx_state <= T_HOLD;
                end
                // READY drops only after the core latches WE; give it a cycle.
                T_HOLD:  r_tx_state <= T_IDLE;
                default: begin
                    r_tx_we    <= 1'b0;
                    r_tx_state <= T_IDLE;
                end
            endcase
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.valid = r_valid;
    assign irq       = r_irq;
endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_uart_fifo
// Purpose  : Directed self-checking bench for mmio_uart_fifo (depth 4, 8 clk/bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_fifo;
    localparam int BIT = 8;

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    wire  txd;
    wire  irq;

    int checks   = 0;
    int failures = 0;
    int tx_q[$];
    logic [7:0] mon_b;
    int         mon_ok;
    int         n;

    mmio_uart_fifo_if #(.ADDR_W(16)) bus ();

    mmio_uart_fifo #(
        .ADDR_W(16), .CPU_FREQ(8), .BAUDRATE(1), .TX_DEPTH(4), .RX_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .txd(txd), .rxd(rxd), .irq(irq)
    );

    always #5 clk = ~clk;

    // Serial line decoder: frames with a bad start/stop bit are logged as -1.
    initial begin
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                repeat (BIT/2) @(negedge clk);
                mon_ok = (txd === 1'b0) ? 1 : 0;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    mon_b[i] = txd;
                end
                repeat (BIT) @(negedge clk);
                if (txd !== 1'b1) mon_ok = 0;
                tx_q.push_back(mon_ok != 0 ? int'(mon_b) : -1);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        bus.oe = 1'b1; bus.we = 4'hF; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        bus.oe = 1'b0; bus.we = 4'h0;
    endtask

    task automatic bus_read(input logic [15:0] a, input string tag, input logic [31:0] exp);
        bus.oe = 1'b1; bus.we = 4'h0; bus.addr = a;
        @(posedge clk); #1;
        bus.oe = 1'b0;
        check({tag, "_valid"}, 32'(bus.valid), 32'd1);
        check(tag, bus.rdata, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rxd = 1'b0;
        repeat (BIT) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(posedge clk); #1;
        end
        rxd = 1'b1;
        repeat (BIT) @(posedge clk); #1;
    endtask

    task automatic wait_tx_bytes(input int want);
        int k;
        k = 0;
        while (tx_q.size() < want && k < 1500) begin
            @(posedge clk); k++;
        end
        #1;
        check("tx_bytes_seen", 32'(tx_q.size()), 32'(want));
    endtask

    task automatic wait_rx_valid();
        int k;
        k = 0;
        while (dut.w_rx_valid !== 1'b1 && k < 300) begin
            @(negedge clk); k++;
        end
        check("rx_valid_seen", 32'(k < 300), 32'd1);
    endtask

    initial begin
        rst = 1'b1; rxd = 1'b1;
        bus.oe = 1'b0; bus.we = 4'h0; bus.addr = '0; bus.wdata = '0;
        cycles(3);
        rst = 1'b0;

        // Reset state
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_irq",   32'(irq), 32'd0);
        check("rst_txd",   32'(txd), 32'd1);
        bus_read(16'h4, "rst_status", 32'h0000000A);
        cycles(1);
        check("valid_one_cycle", 32'(bus.valid), 32'd0);
        bus_read(16'h0, "rst_data", 32'h80000000);
        bus_read(16'h8, "rst_ctrl", 32'h0);
        bus_read(16'hC, "reg_c",    32'h0);
        bus_write(16'hC, 32'hFFFF_FFFF);
        check("write_no_valid", 32'(bus.valid), 32'd0);
        bus_read(16'h4, "status_after_c_write", 32'h0000000A);

        // TX overflow: 0x41 is handed off before the FIFO fills, 0x46 is dropped
        for (int b = 8'h41; b <= 8'h46; b++) bus_write(16'h0, 32'(b));
        bus_read(16'h4, "tx_ovf_status", 32'h00000419);
        bus_write(16'h4, 32'h10);
        bus_read(16'h4, "tx_drop_clear", 32'h00000409);
        wait_tx_bytes(5);
        for (int i = 0; i < 5; i++)
            check($sformatf("tx_byte%0d", i), 32'((tx_q.size() > i) ? tx_q[i] : -2), 32'(8'h41 + i));
        cycles(20);
        bus_read(16'h4, "tx_drained", 32'h0000000A);

        // RX overrun
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55);
        cycles(10);
        bus_read(16'h4, "rx_ovr_status", 32'h00040026);
        bus_read(16'h0, "rx_pop0", 32'h00000011);
        bus_read(16'h0, "rx_pop1", 32'h00000022);
        bus_read(16'h0, "rx_pop2", 32'h00000033);
        bus_read(16'h0, "rx_pop3", 32'h00000044);
        bus_read(16'h0, "rx_pop_empty", 32'h80000000);
        bus_write(16'h4, 32'h20);
        bus_read(16'h4, "rx_ovr_clear", 32'h0000000A);

        // Full RX FIFO: CPU pop coincides with a receive
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        cycles(10);
        bus_read(16'h4, "rx_full_status", 32'h00040006);
        fork
            send_byte(8'hA5);
            begin
                wait_rx_valid();
                bus.oe = 1'b1; bus.we = 4'h0; bus.addr = 16'h0;
                @(posedge clk); #1;
                bus.oe = 1'b0;
                check("col_valid", 32'(bus.valid), 32'd1);
                check("col_data",  bus.rdata, 32'h000000A1);
            end
        join
        cycles(2);
        bus_read(16'h4, "col_status", 32'h00040006);
        bus_read(16'h0, "col_pop1", 32'h000000A2);
        bus_read(16'h0, "col_pop2", 32'h000000A3);
        bus_read(16'h0, "col_pop3", 32'h000000A4);
        bus_read(16'h0, "col_pop4", 32'h000000A5);
        bus_read(16'h0, "col_empty", 32'h80000000);

        // Interrupt
        bus_write(16'h8, 32'h1);
        cycles(2);
        check("irq_rx_none", 32'(irq), 32'd0);
        send_byte(8'h5A);
        cycles(3);
        check("irq_rx_pending", 32'(irq), 32'd1);
        bus_read(16'h0, "irq_pop", 32'h0000005A);
        check("irq_same_edge", 32'(irq), 32'd1);
        cycles(1);
        check("irq_fell", 32'(irq), 32'd0);
        bus_write(16'h8, 32'h2);
        cycles(2);
        check("irq_tx_empty", 32'(irq), 32'd1);
        bus_read(16'h8, "ctrl_rb", 32'h2);
        bus_write(16'h8, 32'h0);
        cycles(2);
        check("irq_off", 32'(irq), 32'd0);

        // TX flush during a burst: only the in-flight 0x61 goes out
        for (int b = 8'h61; b <= 8'h64; b++) bus_write(16'h0, 32'(b));
        bus_read(16'h4, "tx_burst_status", 32'h00000308);
        bus_write(16'h8, 32'h8);
        bus_read(16'h4, "tx_flush_status", 32'h0000000A);
        bus_read(16'h8, "flush_reads_zero", 32'h0);
        wait_tx_bytes(6);
        check("tx_inflight", 32'((tx_q.size() > 5) ? tx_q[5] : -2), 32'h61);
        cycles(300);
        check("tx_no_more", 32'(tx_q.size()), 32'd6);

        // RX flush beats a same-cycle receive
        send_byte(8'h76);
        cycles(10);
        bus_read(16'h4, "rx_one_status", 32'h00010002);
        fork
            send_byte(8'h77);
            begin
                wait_rx_valid();
                bus.oe = 1'b1; bus.we = 4'hF; bus.addr = 16'h8; bus.wdata = 32'h4;
                @(posedge clk); #1;
                bus.oe = 1'b0; bus.we = 4'h0;
            end
        join
        cycles(2);
        bus_read(16'h4, "rx_flush_status", 32'h0000000A);
        bus_read(16'h0, "rx_flush_data", 32'h80000000);

        n = checks;
        $display("TB_RESULT checks=%0d failures=%0d", n, failures);
        $finish;
    end
endmodule
`default_nettype wire
